mux_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one MUX_N datapath (16 x NBITS inputs, 4-bit selection) among up to 16 requesters. It registers a one-hot grant plus the matching binary selection driven straight onto MUX_N.selection. Grant tenure is bounded by a hold limit so no requester starves.

---
 rtl/mux_rr_arbiter.sv | 159 +++++++++++++++
 tb/tb_mux_rr_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter owning the select lines of a shared MUX_N datapath.
// Optional build macro MUX_ARB_LOCK_EN lets the current owner suspend the hold limit via lock.
module mux_rr_arbiter #(
  parameter int unsigned NREQ     = 16,
  parameter int unsigned SELW     = 4,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            lock,
  output logic [NREQ-1:0] grant,
  output logic            valid,
  output logic [SELW-1:0] selection,
  output logic [3:0]      hold_cnt
);

  localparam logic [3:0]      MaxHold  = 4'(MAX_HOLD);
  localparam logic [SELW-1:0] LastInit = SELW'(NREQ - 1);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic            valid_q, valid_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [SELW-1:0] last_q, last_d;
  logic [3:0]      hold_q, hold_d;

  logic [NREQ-1:0] others;
  logic            owner_req;
  logic            lock_hold;
  logic [SELW-1:0] pick_any, pick_other;
  logic            new_grant;
  logic [SELW-1:0] new_idx;

  // First set bit strictly after 'from', ascending with wrap; 'from' itself is checked last.
  function automatic logic [SELW-1:0] rr_pick(input logic [NREQ-1:0] vec,
                                              input logic [SELW-1:0] from);
    logic [2*NREQ-1:0] dbl;
    logic [SELW-1:0]   pick;
    logic              found;
    int unsigned       start;
    pick  = from;
    found = 1'b0;
    start = (32'(from) + 32'd1) % NREQ;
    dbl   = {vec, vec} >> start;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && dbl[i]) begin
        pick  = SELW'((start + i) % NREQ);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [NREQ-1:0] to_onehot(input logic [SELW-1:0] idx);
    logic [NREQ-1:0] oh;
    for (int unsigned i = 0; i < NREQ; i++) begin
      oh[i] = (32'(idx) == i);
    end
    return oh;
  endfunction

`ifdef MUX_ARB_LOCK_EN
  assign lock_hold = lock;
`else
  logic lock_unused;
  assign lock_unused = lock;
  assign lock_hold   = 1'b0;
`endif

  assign owner_req  = |(req & grant_q);
  assign others     = req & ~grant_q;
  assign pick_any   = rr_pick(req, last_q);
  assign pick_other = rr_pick(others, last_q);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    valid_d   = valid_q;
    sel_d     = sel_q;
    last_d    = last_q;
    hold_d    = hold_q;
    new_grant = 1'b0;
    new_idx   = sel_q;

    unique case (state_q)
      StIdle: begin
        if (|req) begin
          new_grant = 1'b1;
          new_idx   = pick_any;
        end
      end
      StGrant: begin
        if (!owner_req) begin
          if (|others) begin
            new_grant = 1'b1;
            new_idx   = pick_other;
          end else begin
            // Selection keeps the last owner so the mux output stays stable while idle.
            state_d = StIdle;
            grant_d = '0;
            valid_d = 1'b0;
            hold_d  = 4'd0;
          end
        end else if (lock_hold) begin
          if (hold_q < MaxHold) hold_d = hold_q + 4'd1;
        end else if (hold_q < MaxHold) begin
          hold_d = hold_q + 4'd1;
        end else if (|others) begin
          new_grant = 1'b1;
          new_idx   = pick_other;
        end else begin
          hold_d = 4'd1;
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
        valid_d = 1'b0;
        hold_d  = 4'd0;
      end
    endcase

    if (new_grant) begin
      state_d = StGrant;
      grant_d = to_onehot(new_idx);
      valid_d = 1'b1;
      sel_d   = new_idx;
      last_d  = new_idx;
      hold_d  = 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      grant_q <= '0;
      valid_q <= 1'b0;
      sel_q   <= '0;
      last_q  <= LastInit;
      hold_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  assign grant     = grant_q;
  assign valid     = valid_q;
  assign selection = sel_q;
  assign hold_cnt  = hold_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: directed vector table, hand-written corner sequences and
// randomized traffic checked against a behavioural round-robin model.
module tb_mux_rr_arbiter;

  localparam int NREQ     = 16;
  localparam int SELW     = 4;
  localparam int MAX_HOLD = 4;
`ifdef MUX_ARB_LOCK_EN
  localparam bit LockEn = 1'b1;
`else
  localparam bit LockEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lock;
  logic [15:0] req;
  logic [15:0] grant;
  logic        valid;
  logic [3:0]  selection;
  logic [3:0]  hold_cnt;

  int checks   = 0;
  int failures = 0;

  // Model state: owner index (-1 when idle), last owner, tenure, selection.
  int m_owner, m_last, m_hold, m_sel;

  typedef struct {
    logic [15:0] req;
    logic [15:0] grant;
    logic [3:0]  sel;
    logic [3:0]  hold;
    logic        valid;
  } vec_t;

  vec_t tbl[$];

  mux_rr_arbiter #(
    .NREQ    (NREQ),
    .SELW    (SELW),
    .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .lock     (lock),
    .grant    (grant),
    .valid    (valid),
    .selection(selection),
    .hold_cnt (hold_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic int pick(input logic [15:0] r, input int excl);
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (m_last + k) % NREQ;
      if (r[idx] && idx != excl) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_last  = NREQ - 1;
    m_hold  = 0;
    m_sel   = 0;
  endtask

  task automatic model_take(input int w);
    m_owner = w;
    m_last  = w;
    m_sel   = w;
    m_hold  = 1;
  endtask

  task automatic model_step(input logic [15:0] r, input logic l);
    int w;
    if (m_owner < 0) begin
      w = pick(r, -1);
      if (w >= 0) model_take(w);
    end else if (!r[m_owner]) begin
      w = pick(r, -1);
      if (w >= 0) model_take(w);
      else begin
        m_owner = -1;
        m_hold  = 0;
      end
    end else if (LockEn && l) begin
      if (m_hold < MAX_HOLD) m_hold++;
    end else if (m_hold < MAX_HOLD) begin
      m_hold++;
    end else begin
      w = pick(r, m_owner);
      if (w >= 0) model_take(w);
      else m_hold = 1;
    end
  endtask

  task automatic check_model(input string tag);
    logic [15:0] eg;
    eg = (m_owner < 0) ? 16'h0 : 16'(1 << m_owner);
    chk({tag, " grant"}, 32'(grant), 32'(eg));
    chk({tag, " valid"}, 32'(valid), 32'(m_owner >= 0));
    chk({tag, " selection"}, 32'(selection), 32'(m_sel));
    chk({tag, " hold_cnt"}, 32'(hold_cnt), 32'(m_hold));
    chk({tag, " onehot0"}, 32'($onehot0(grant)), 32'd1);
    chk({tag, " grant_at_sel"}, 32'(valid ? grant[selection] : 1'b1), 32'd1);
  endtask

  task automatic cycle(input logic [15:0] r, input logic l, input string tag);
    req  = r;
    lock = l;
    @(posedge clk);
    model_step(r, l);
    #1;
    check_model(tag);
  endtask

  initial begin
    logic [15:0] rr;
    rst_n = 1'b0;
    req   = '0;
    lock  = 1'b0;
    model_reset();
    #1;
    chk("reset grant", 32'(grant), 32'h0);
    chk("reset valid", 32'(valid), 32'h0);
    chk("reset selection", 32'(selection), 32'h0);
    chk("reset hold_cnt", 32'(hold_cnt), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single grant/release, two-way rotation at hold limit, wrap-around, handoffs.
    tbl.push_back('{16'h0001, 16'h0001, 4'd0,  4'd1, 1'b1});
    tbl.push_back('{16'h0000, 16'h0000, 4'd0,  4'd0, 1'b0});
    tbl.push_back('{16'h0006, 16'h0002, 4'd1,  4'd1, 1'b1});
    tbl.push_back('{16'h0006, 16'h0002, 4'd1,  4'd2, 1'b1});
    tbl.push_back('{16'h0006, 16'h0002, 4'd1,  4'd3, 1'b1});
    tbl.push_back('{16'h0006, 16'h0002, 4'd1,  4'd4, 1'b1});
    tbl.push_back('{16'h0006, 16'h0004, 4'd2,  4'd1, 1'b1});
    tbl.push_back('{16'h0006, 16'h0004, 4'd2,  4'd2, 1'b1});
    tbl.push_back('{16'h0006, 16'h0004, 4'd2,  4'd3, 1'b1});
    tbl.push_back('{16'h0006, 16'h0004, 4'd2,  4'd4, 1'b1});
    tbl.push_back('{16'h0006, 16'h0002, 4'd1,  4'd1, 1'b1});
    tbl.push_back('{16'h4000, 16'h4000, 4'd14, 4'd1, 1'b1});
    tbl.push_back('{16'h8001, 16'h8000, 4'd15, 4'd1, 1'b1});
    tbl.push_back('{16'h8001, 16'h8000, 4'd15, 4'd2, 1'b1});
    tbl.push_back('{16'h8001, 16'h8000, 4'd15, 4'd3, 1'b1});
    tbl.push_back('{16'h8001, 16'h8000, 4'd15, 4'd4, 1'b1});
    tbl.push_back('{16'h8001, 16'h0001, 4'd0,  4'd1, 1'b1});
    tbl.push_back('{16'h0008, 16'h0008, 4'd3,  4'd1, 1'b1});
    tbl.push_back('{16'h0200, 16'h0200, 4'd9,  4'd1, 1'b1});
    tbl.push_back('{16'h0000, 16'h0000, 4'd9,  4'd0, 1'b0});

    foreach (tbl[i]) begin
      cycle(tbl[i].req, 1'b0, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d tbl_grant", i), 32'(grant), 32'(tbl[i].grant));
      chk($sformatf("vec%0d tbl_sel", i), 32'(selection), 32'(tbl[i].sel));
      chk($sformatf("vec%0d tbl_hold", i), 32'(hold_cnt), 32'(tbl[i].hold));
      chk($sformatf("vec%0d tbl_valid", i), 32'(valid), 32'(tbl[i].valid));
    end

    // Lone requester 5: tenure counter wraps after the limit, selection steady.
    for (int k = 0; k < 10; k++) begin
      cycle(16'h0020, 1'b0, "solo5");
      chk("solo5 hold_seq", 32'(hold_cnt), 32'((k % MAX_HOLD) + 1));
      chk("solo5 sel", 32'(selection), 32'd5);
    end

    // Asynchronous reset while requester 7 owns the mux.
    cycle(16'h0080, 1'b0, "own7");
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst grant", 32'(grant), 32'h0);
    chk("async_rst valid", 32'(valid), 32'h0);
    chk("async_rst selection", 32'(selection), 32'h0);
    chk("async_rst hold_cnt", 32'(hold_cnt), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(16'h0080, 1'b0, "post_rst");
    chk("post_rst grant7", 32'(grant), 32'h0080);

`ifdef MUX_ARB_LOCK_EN
    for (int k = 0; k < 10; k++) begin
      cycle(16'h0011, 1'b1, "lock");
      chk("lock grant0", 32'(grant), 32'h0001);
    end
    chk("lock hold_sat", 32'(hold_cnt), 32'(MAX_HOLD));
    cycle(16'h0011, 1'b0, "unlock");
    chk("unlock grant4", 32'(grant), 32'h0010);
`endif

    // Randomized traffic; requests are sticky most cycles so hold limits get exercised.
    rr = '0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        unique case ((n / 200) % 4)
          0: rr = 16'($urandom);
          1: rr = 16'($urandom & $urandom & $urandom);
          2: rr = 16'(1 << $urandom_range(0, 15)) | 16'(1 << $urandom_range(0, 15));
          default: rr = ($urandom_range(0, 4) == 0) ? 16'h0 : 16'($urandom & $urandom);
        endcase
      end
      cycle(rr, 1'($urandom_range(0, 1)), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
